// File: rtl/tdc_meas_ctrl_pkg.sv
// Shared encodings and constants for the TDC measurement sequencer.
// Tap-line sizing defaults live here so datapath and control agree.
`ifndef DIG_OUT
`define DIG_OUT 8
`endif
`ifndef NUM_TAPS
`define NUM_TAPS 128
`endif

package tdc_meas_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM_WAIT = 3'd1,
    ARMED    = 3'd2,
    RUN      = 3'd3,
    CONV     = 3'd4,
    RESULT   = 3'd5
  } state_t;

  localparam int DIG_OUT  = `DIG_OUT;
  localparam int NUM_TAPS = `NUM_TAPS;

endpackage

// File: rtl/tdc_hit_sync.sv
// Two-flop synchronizer plus delay flop with rise/fall detect.
// Reusable for any asynchronous single-bit input.
module tdc_hit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arm, coarse count, merge handshake, readout.
// Define TDC_TIMEOUT_CNT_EN to add the saturating oTimeoutCnt output.
module tdc_meas_ctrl
  import tdc_meas_ctrl_pkg::*;
#(
  parameter int COARSE_W    = 16,
  parameter int FINE_W      = DIG_OUT,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ARM_DELAY   = 4
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iEnable,
  input  logic                iSingle,
  input  logic                iHit,
  output logic                oArm,
  output logic                oConvStart,
  input  logic                iConvDone,
  input  logic [FINE_W-1:0]   iFineStart,
  input  logic [FINE_W-1:0]   iFineStop,
  output logic                oValid,
  input  logic                iReady,
  output logic [COARSE_W-1:0] oCoarse,
  output logic [FINE_W-1:0]   oFineStart,
  output logic [FINE_W-1:0]   oFineStop,
  output logic                oTimeout,
  output logic                oBusy
`ifdef TDC_TIMEOUT_CNT_EN
  ,
  output logic [7:0]          oTimeoutCnt
`endif
);

  localparam int SET_W = $clog2(ARM_DELAY + 1);
  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'(ARM_DELAY - 1);
  localparam logic [COARSE_W-1:0] TMO =
    COARSE_W'(TIMEOUT_CYC);

  state_t state_q;
  state_t state_d;

  logic                single_q;
  logic [SET_W-1:0]    settle_q;
  logic [COARSE_W-1:0] cnt_q;
  logic                conv_first_q;

  logic hit_lvl;
  logic hit_rise;
  logic hit_fall;

  logic settled;
  logic start_run;
  logic load_coarse;
  logic load_tmo;
  logic load_fine;
  logic hs;

  tdc_hit_sync u_hit_sync (
    .clk   (iClk),
    .rst_n (iRst_n),
    .din   (iHit),
    .level (hit_lvl),
    .rise  (hit_rise),
    .fall  (hit_fall)
  );

  assign settled = (settle_q == SET_LAST);

  always_comb begin
    state_d     = state_q;
    start_run   = 1'b0;
    load_coarse = 1'b0;
    load_tmo    = 1'b0;
    load_fine   = 1'b0;
    hs          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iEnable || iSingle)
          state_d = ARM_WAIT;
      end
      ARM_WAIT: begin
        if (settled && !hit_lvl)
          state_d = ARMED;
      end
      ARMED: begin
        if (hit_rise) begin
          start_run = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        // fall has priority over a coincident timeout
        if (hit_fall) begin
          load_coarse = 1'b1;
          state_d     = CONV;
        end else if (cnt_q == TMO) begin
          load_tmo = 1'b1;
          state_d  = RESULT;
        end
      end
      CONV: begin
        if (iConvDone) begin
          load_fine = 1'b1;
          state_d   = RESULT;
        end
      end
      RESULT: begin
        if (iReady) begin
          hs = 1'b1;
          if (iEnable && !single_q)
            state_d = ARM_WAIT;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q      <= IDLE;
      single_q     <= 1'b0;
      settle_q     <= '0;
      cnt_q        <= '0;
      conv_first_q <= 1'b0;
      oCoarse      <= '0;
      oFineStart   <= '0;
      oFineStop    <= '0;
      oTimeout     <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_first_q <= load_coarse;
      if (state_q == IDLE && state_d == ARM_WAIT)
        single_q <= iSingle & ~iEnable;
      if (state_q == ARM_WAIT) begin
        if (!settled)
          settle_q <= settle_q + 1'b1;
      end else begin
        settle_q <= '0;
      end
      if (start_run)
        cnt_q <= COARSE_W'(1);
      else if (state_q == RUN)
        cnt_q <= cnt_q + 1'b1;
      if (load_coarse)
        oCoarse <= cnt_q;
      if (load_tmo) begin
        oCoarse    <= TMO;
        oTimeout   <= 1'b1;
        oFineStart <= '0;
        oFineStop  <= '0;
      end
      if (load_fine) begin
        oFineStart <= iFineStart;
        oFineStop  <= iFineStop;
      end
      if (hs)
        oTimeout <= 1'b0;
    end
  end

`ifdef TDC_TIMEOUT_CNT_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)
      oTimeoutCnt <= 8'd0;
    else if (hs && oTimeout && oTimeoutCnt != 8'hFF)
      oTimeoutCnt <= oTimeoutCnt + 8'd1;
  end
`endif

  assign oArm = (state_q == ARM_WAIT) ||
                (state_q == ARMED) ||
                (state_q == RUN);
  assign oConvStart = (state_q == CONV) && conv_first_q;
  assign oValid     = (state_q == RESULT);
  assign oBusy      = (state_q != IDLE);

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the tapped-delay-line TDC.
- Arms the capture flip-flops and synchronizes the asynchronous hit.
- Counts coarse clock cycles of the hit pulse, then triggers the thermometer-to-binary merge stage.
- Collects the fine start/stop codes and presents one result record to the readout via valid/ready.
- Sits between the top-level hit input and the tap/merge datapath.

Parameters:
COARSE_W, 16, width of the coarse cycle counter and oCoarse
FINE_W, 8, width of each converted fine code (equals `DIG_OUT in top)
TIMEOUT_CYC, 1024, maximum coarse count before a measurement is aborted; must be < 2**COARSE_W
ARM_DELAY, 4, settle cycles between arming and accepting a hit

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous active-low reset
iEnable  in  1  level; continuous re-arm while high
iSingle  in  1  one-cycle pulse; arms a single measurement from IDLE
iHit  in  1  asynchronous hit input
oArm  out  1  enables TDC start/stop capture flip-flops
oConvStart  out  1  one-cycle pulse starting the merge conversion
iConvDone  in  1  merge stage done (pulse or level)
iFineStart  in  FINE_W  converted start fine code, valid when iConvDone
iFineStop  in  FINE_W  converted stop fine code, valid when iConvDone
oValid  out  1  result record available
iReady  in  1  readout accepts the record
oCoarse  out  COARSE_W  coarse hit width in clock cycles
oFineStart  out  FINE_W  latched start fine code
oFineStop  out  FINE_W  latched stop fine code
oTimeout  out  1  record is a timeout (no stop edge)
oBusy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, iRst_n=0): state IDLE; all outputs 0; synchronizer flops 0; counters 0.
- Hit path: 2-flop synchronizer plus one delay flop.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Detection latency is 2-3 cycles from the iHit edge.
- IDLE: enter ARM_WAIT when iEnable=1 or iSingle=1.
  - Latch a single flag = iSingle & ~iEnable.
- ARM_WAIT: oArm=1.
  - Wait until the settle counter reaches ARM_DELAY and synchronized hit is low; then go to ARMED.
  - A hit already high keeps the block in ARM_WAIT until it goes low.
- ARMED: oArm=1.
  - On rise: coarse counter := 1, go to RUN.
- RUN: oArm=1; coarse counter increments each cycle.
  - On fall: latch the counter into oCoarse; go to CONV.
  - A hit high for N whole cycles gives oCoarse=N.
  - If the counter equals TIMEOUT_CYC with no fall: oCoarse := TIMEOUT_CYC, oTimeout := 1, fine outputs := 0; go to RESULT and skip conversion.
  - Simultaneous fall and timeout in the same cycle: fall wins.
- CONV: oArm=0.
  - oConvStart=1 only in the first CONV cycle.
  - Wait for iConvDone; latch iFineStart/iFineStop; go to RESULT.
  - iConvDone asserted in the oConvStart cycle is accepted.
- RESULT: oValid=1; record held stable until iValid&iReady handshake completes (oValid & iReady).
  - On handshake: oValid=0 next cycle, oTimeout cleared.
  - Next state: ARM_WAIT if iEnable=1 and single flag=0, else IDLE.
  - iReady may be high before oValid; zero-wait acceptance allowed.
- iEnable falling mid-measurement: current measurement completes and is delivered, then IDLE.
- iSingle outside IDLE is ignored.
- Hits arriving in CONV/RESULT are ignored. The edge detector is re-qualified in ARM_WAIT, so no stale edge is used.
- Throughput: at most one record in flight; no buffering.

Optional Feature:
TDC_TIMEOUT_CNT_EN
- Defined: adds output oTimeoutCnt [7:0], a saturating count of timeout records at 255.
  - Increments on the RESULT handshake of a timeout record.
  - Cleared only by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package/defines: state encoding localparams (IDLE, ARM_WAIT, ARMED, RUN, CONV, RESULT), `DIG_OUT, `NUM_TAPS.
- One sub-module: tdc_hit_sync (2-flop synchronizer plus edge detect, async active-low reset), reusable for other async inputs.

Test Plan:
- Reset and arm:
  - Reset 5 ns, then iEnable=1 -> oArm rises within 1 cycle.
  - ARMED reached after ARM_DELAY=4 cycles.
  - All outputs 0 during reset.
- Basic measurement (TCLK 8 ns):
  - iHit high 16 ns, clock-aligned -> oCoarse=2 and one oConvStart pulse.
  - Drive iConvDone with iFineStart=8'h1A, iFineStop=8'h05 -> oValid with those values; oTimeout=0.
- Backpressure:
  - iReady=0 for 10 cycles -> record stable and oValid held.
  - iReady=1 -> oValid drops next cycle; re-arm via ARM_WAIT.
- Timeout:
  - TIMEOUT_CYC=1024, hit held high -> oCoarse=1024, oTimeout=1, fine codes 0, no oConvStart.
  - With TDC_TIMEOUT_CNT_EN defined -> oTimeoutCnt=1 after handshake.
- Single-shot and disable:
  - iSingle pulse with iEnable=0 -> exactly one record, then IDLE and oBusy=0.
  - iEnable dropped during RUN -> record delivered, then IDLE.
- Reset mid-operation:
  - iRst_n low during CONV -> immediate IDLE, oValid=0, oArm=0.
  - A late iConvDone after reset is ignored.
